// File: rtl/databus_native_bridge.sv
`default_nettype none
// ============================================================================
// Module      : databus_native_bridge
// Description : Serves a burst databus port (valid/ready/addr/len/last) from
//               a single-word native memory port. A burst request is latched
//               and then one native access is issued per beat, with the byte
//               address stepping by one word each beat. Read beats are handed
//               to the unit through a one-entry holding register. Write beats
//               are forwarded from the unit to memory.
// Revision    : 1.0 - initial release
// ============================================================================
module databus_native_bridge #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [ADDR_W-1:0]   s_addr,
    input  logic [LEN_W-1:0]    s_len,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W-1:0]   s_rdata,
    output logic                s_last,
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_ready,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                busy,
    output logic                done
);

    localparam int                c_STRB_W     = DATA_W / 8;
    localparam logic [ADDR_W-1:0] c_BEAT_BYTES = ADDR_W'(c_STRB_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RREQ  = 3'd1,
        S_RHOLD = 3'd2,
        S_WDATA = 3'd3,
        S_WREQ  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_W-1:0]     r_base;
    logic [LEN_W-1:0]      r_len;
    logic [c_STRB_W-1:0]   r_wstrb;
    logic [LEN_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_buf;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_done;

    logic                  w_last;
    logic                  w_start;
    logic                  w_rd_ack;
    logic                  w_rd_take;
    logic                  w_wr_take;
    logic                  w_wr_ack;
    logic                  w_beat_end;
    logic [ADDR_W-1:0]     w_offset;

    // Handshake events, all qualified by the registered state.
    assign w_last     = (r_cnt == r_len);
    assign w_start    = (r_state == S_IDLE)  && s_valid;
    assign w_rd_ack   = (r_state == S_RREQ)  && m_ready;
    assign w_rd_take  = (r_state == S_RHOLD) && s_valid;
    assign w_wr_take  = (r_state == S_WDATA) && s_valid;
    assign w_wr_ack   = (r_state == S_WREQ)  && m_ready;
    assign w_beat_end = w_rd_take || w_wr_ack;

    // Beat address wraps modulo 2^ADDR_W; unaligned base bits pass through.
    assign w_offset = ADDR_W'(r_cnt) * c_BEAT_BYTES;
    assign m_addr   = r_base + w_offset;
    assign m_wdata  = r_wdata;
    assign s_rdata  = r_buf;
    assign done     = r_done;

    // State register; reset drops back to IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs (no path from m_ready to s_ready).
    always_comb begin
        w_state_next = r_state;
        s_ready      = 1'b0;
        s_last       = 1'b0;
        m_valid      = 1'b0;
        m_wstrb      = '0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (s_valid) begin
                    w_state_next = (s_wstrb == '0) ? S_RREQ : S_WDATA;
                end
            end
            S_RREQ: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    w_state_next = S_RHOLD;
                end
            end
            S_RHOLD: begin
                s_ready = 1'b1;
                s_last  = w_last;
                if (s_valid) begin
                    w_state_next = w_last ? S_IDLE : S_RREQ;
                end
            end
            S_WDATA: begin
                s_ready = 1'b1;
                s_last  = w_last;
                if (s_valid) begin
                    w_state_next = S_WREQ;
                end
            end
            S_WREQ: begin
                m_valid = 1'b1;
                m_wstrb = r_wstrb;
                if (m_ready) begin
                    w_state_next = w_last ? S_IDLE : S_WDATA;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Burst latches, beat counter, data holding registers and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base  <= '0;
            r_len   <= '0;
            r_wstrb <= '0;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_beat_end && w_last;
            if (w_start) begin
                r_base  <= s_addr;
                r_len   <= s_len;
                r_wstrb <= s_wstrb;
                r_cnt   <= '0;
            end else if (w_beat_end && !w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_rd_ack) begin
                r_buf <= m_rdata;
            end
            if (w_wr_take) begin
                r_wdata <= s_wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_databus_native_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_databus_native_bridge
// Description : Directed self-checking bench for databus_native_bridge with a
//               scoreboard of expected native addresses, read data, last
//               flags and write data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_databus_native_bridge;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] s_addr;
    logic [LEN_W-1:0]  s_len;
    logic [3:0]        s_wstrb;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W-1:0] s_rdata;
    logic              s_last;
    logic              m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [3:0]        m_wstrb;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_rdata[$];
    logic        q_last[$];
    logic [31:0] q_wdata[$];

    databus_native_bridge #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_addr  (s_addr),
        .s_len   (s_len),
        .s_wstrb (s_wstrb),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .m_wstrb (m_wstrb),
        .m_wdata (m_wdata),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Memory contents model: 0x100 holds 0xDEADBEEF, other words derive from address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_read(input logic [31:0] base, input int len);
        logic [31:0] a;
        for (int i = 0; i <= len; i++) begin
            a = base + 32'(i) * 32'd4;
            q_addr.push_back(a);
            q_rdata.push_back(mem_word(a));
            q_last.push_back(i == len);
        end
    endtask

    task automatic start_burst(input logic [31:0] a, input logic [7:0] len, input logic [3:0] strb);
        s_addr  = a;
        s_len   = len;
        s_wstrb = strb;
        s_valid = 1'b1;
        check("start_no_ready", {63'd0, s_ready}, 64'd0);
        tick();
        s_valid = 1'b0;
        check("start_busy", {63'd0, busy}, 64'd1);
    endtask

    // Native memory responder: checks the request, waits, then completes it.
    task automatic mem_serve(input int wait_cyc, input logic [3:0] exp_strb);
        int          n;
        logic [31:0] exp_a;
        n = 0;
        while (!m_valid && n < 20) begin
            tick();
            n++;
        end
        check("m_valid_timeout", {63'd0, m_valid}, 64'd1);
        exp_a = q_addr.pop_front();
        check("m_addr", {32'd0, m_addr}, {32'd0, exp_a});
        check("m_wstrb", {60'd0, m_wstrb}, {60'd0, exp_strb});
        if (exp_strb != 4'h0) begin
            check("m_wdata", {32'd0, m_wdata}, {32'd0, q_wdata.pop_front()});
        end
        for (int i = 0; i < wait_cyc; i++) begin
            tick();
            check("m_valid_hold", {63'd0, m_valid}, 64'd1);
            check("m_addr_hold", {32'd0, m_addr}, {32'd0, exp_a});
        end
        m_rdata = mem_word(exp_a);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        m_rdata = 32'h0;
    endtask

    // Unit takes one read beat after `gap` cycles of backpressure.
    task automatic rd_take(input int gap, input bit keep);
        logic [31:0] exp_d;
        logic        exp_l;
        exp_d = q_rdata.pop_front();
        exp_l = q_last.pop_front();
        for (int i = 0; i < gap; i++) begin
            s_valid = 1'b0;
            tick();
            check("rhold_ready", {63'd0, s_ready}, 64'd1);
            check("rhold_data", {32'd0, s_rdata}, {32'd0, exp_d});
            check("rhold_no_mvalid", {63'd0, m_valid}, 64'd0);
        end
        check("rd_ready", {63'd0, s_ready}, 64'd1);
        check("rd_data", {32'd0, s_rdata}, {32'd0, exp_d});
        check("rd_last", {63'd0, s_last}, {63'd0, exp_l});
        s_valid = 1'b1;
        tick();
        if (!keep) s_valid = 1'b0;
        check("rd_done", {63'd0, done}, {63'd0, exp_l});
        check("rd_busy", {63'd0, busy}, {63'd0, !exp_l});
    endtask

    task automatic wr_give(input logic [31:0] d, input logic exp_l);
        check("wr_ready", {63'd0, s_ready}, 64'd1);
        check("wr_last", {63'd0, s_last}, {63'd0, exp_l});
        s_wdata = d;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("wr_req", {63'd0, m_valid}, 64'd1);
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_addr  = '0;
        s_len   = '0;
        s_wstrb = '0;
        s_wdata = '0;
        m_ready = 1'b0;
        m_rdata = '0;
        tick();
        tick();

        // Reset state.
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_s_ready", {63'd0, s_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_s_last", {63'd0, s_last}, 64'd0);
        check("rst_m_addr", {32'd0, m_addr}, 64'd0);
        check("rst_s_rdata", {32'd0, s_rdata}, 64'd0);
        check("rst_m_wdata", {32'd0, m_wdata}, 64'd0);
        check("rst_m_wstrb", {60'd0, m_wstrb}, 64'd0);
        rst = 1'b0;
        tick();

        // Single read with 3 wait cycles.
        push_read(32'h100, 0);
        start_burst(32'h100, 8'd0, 4'h0);
        mem_serve(3, 4'h0);
        check("single_no_mvalid", {63'd0, m_valid}, 64'd0);
        rd_take(0, 1'b0);
        tick();
        check("single_done_pulse", {63'd0, done}, 64'd0);
        check("single_idle_mvalid", {63'd0, m_valid}, 64'd0);

        // Read burst with backpressure on beat 1.
        push_read(32'h200, 3);
        start_burst(32'h200, 8'd3, 4'h0);
        s_addr = 32'hBAD0_0000;
        s_len  = 8'd9;
        mem_serve(1, 4'h0);
        rd_take(0, 1'b0);
        mem_serve(0, 4'h0);
        rd_take(5, 1'b0);
        mem_serve(2, 4'h0);
        rd_take(0, 1'b0);
        mem_serve(0, 4'h0);
        rd_take(1, 1'b0);
        tick();
        check("burst_done_clear", {63'd0, done}, 64'd0);

        // Write burst, immediate native completion.
        q_addr.push_back(32'h300);
        q_wdata.push_back(32'h11);
        q_addr.push_back(32'h304);
        q_wdata.push_back(32'h22);
        start_burst(32'h300, 8'd1, 4'hF);
        wr_give(32'h11, 1'b0);
        mem_serve(0, 4'hF);
        check("wr_mid_done", {63'd0, done}, 64'd0);
        wr_give(32'h22, 1'b1);
        mem_serve(0, 4'hF);
        check("wr_done", {63'd0, done}, 64'd1);
        check("wr_idle_busy", {63'd0, busy}, 64'd0);
        tick();

        // Address wrap.
        push_read(32'hFFFF_FFFC, 1);
        start_burst(32'hFFFF_FFFC, 8'd1, 4'h0);
        mem_serve(0, 4'h0);
        rd_take(0, 1'b0);
        mem_serve(0, 4'h0);
        rd_take(0, 1'b0);
        tick();

        // Reset during the native request of beat 2.
        push_read(32'h500, 7);
        start_burst(32'h500, 8'd7, 4'h0);
        mem_serve(0, 4'h0);
        rd_take(0, 1'b0);
        mem_serve(1, 4'h0);
        rd_take(0, 1'b0);
        check("mid_rreq", {63'd0, m_valid}, 64'd1);
        check("mid_addr", {32'd0, m_addr}, {32'd0, q_addr.pop_front()});
        #2;
        rst = 1'b1;
        #1;
        check("arst_m_valid", {63'd0, m_valid}, 64'd0);
        check("arst_s_ready", {63'd0, s_ready}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_s_rdata", {32'd0, s_rdata}, 64'd0);
        q_addr.delete();
        q_rdata.delete();
        q_last.delete();
        tick();
        rst = 1'b0;
        tick();
        push_read(32'h40, 0);
        start_burst(32'h40, 8'd0, 4'h0);
        mem_serve(0, 4'h0);
        rd_take(0, 1'b0);
        tick();

        // Back-to-back single reads with s_valid held high.
        push_read(32'h600, 0);
        s_addr  = 32'h600;
        s_len   = 8'd0;
        s_wstrb = 4'h0;
        s_valid = 1'b1;
        tick();
        check("b2b_busy", {63'd0, busy}, 64'd1);
        mem_serve(0, 4'h0);
        s_addr = 32'h700;
        rd_take(0, 1'b1);
        push_read(32'h700, 0);
        check("b2b_idle_ready", {63'd0, s_ready}, 64'd0);
        tick();
        check("b2b_restart", {63'd0, busy}, 64'd1);
        check("b2b_done_clear", {63'd0, done}, 64'd0);
        mem_serve(0, 4'h0);
        rd_take(0, 1'b0);
        tick();
        check("b2b_final_idle", {63'd0, busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/databus_native_bridge.md
Name: databus_native_bridge

Overview:
- Sits directly upstream of the VRead/VWrite-style units: serves their burst databus port (valid/ready/addr/len/last) from a single-word native memory port.
- Latches a burst request, then issues one native access per beat with an incrementing byte address.
- Returns read beats through a one-entry holding register, or forwards write beats from the unit to memory.
- Flags the final beat with last.

Parameters:
DATA_W  32  data width of both ports (multiple of 8)
ADDR_W  32  byte address width (matches IO_ADDR_W)
LEN_W   8   burst length field width

Ports:
clk        in   1           clock
rst        in   1           asynchronous active-high reset
s_valid    in   1           unit side: read = unit can accept beat; write = unit presents beat
s_ready    out  1           beat transfers when s_valid & s_ready
s_addr     in   ADDR_W      burst base byte address, sampled at burst start
s_len      in   LEN_W       beats-1, sampled at burst start
s_wstrb    in   DATA_W/8    nonzero at start selects write burst; value applied to every write beat
s_wdata    in   DATA_W      write beat data
s_rdata    out  DATA_W      read beat data
s_last     out  1           current offered/accepted beat is final
m_valid    out  1           native request
m_addr     out  ADDR_W      native byte address
m_wstrb    out  DATA_W/8    native write strobe (0 = read)
m_wdata    out  DATA_W      native write data
m_ready    in   1           native completion; m_rdata valid in the same cycle
m_rdata    in   DATA_W      native read data
busy       out  1           burst in progress
done       out  1           one-cycle pulse after final beat completes

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- Reset state: IDLE. All outputs, beat counter, base/len/wstrb latches and rdata buffer = 0.
- Burst start, IDLE with s_valid=1:
  - latch base=s_addr, len=s_len, wstrb=s_wstrb; cnt=0.
  - Go RREQ if wstrb==0, else WDATA. No s_ready in this cycle.
- Address: m_addr = base + cnt*(DATA_W/8), modulo 2^ADDR_W (wrap silently). Low bits of base are passed through unaligned and unchanged.
- RREQ:
  - m_valid=1, m_wstrb=0. Hold m_valid and m_addr stable until m_ready.
  - On m_ready: capture m_rdata into buf, go RHOLD.
  - s_valid is ignored here; an issued native request is never aborted.
- RHOLD:
  - s_ready=1, s_rdata=buf, s_last=(cnt==len).
  - On s_valid: if last, go IDLE and pulse done next cycle; else cnt++ and go RREQ.
  - buf holds indefinitely while s_valid=0.
- WDATA:
  - s_ready=1, s_last=(cnt==len).
  - On s_valid: latch s_wdata into m_wdata, go WREQ.
- WREQ:
  - m_valid=1, m_wstrb=latched wstrb, stable until m_ready.
  - On m_ready: if cnt==len, go IDLE and pulse done; else cnt++ and go WDATA.
- Throughput: a beat needs at least 2 cycles (request + handoff); no bubble-free overlap.
- Timing of outputs:
  - s_ready, s_last and m_valid are registered-state decodes; no combinational path from m_ready to s_ready.
  - s_last=0 outside RHOLD/WDATA.
- busy=1 in every state except IDLE.
- done is asserted for exactly 1 cycle, in the cycle after the transition to IDLE. A new burst may start in that same cycle if s_valid=1.
- Sampling: s_addr/s_len/s_wstrb changes during a burst are ignored. len=0 gives a single beat with s_last=1 on it. len=2^LEN_W-1 gives 2^LEN_W beats; cnt is LEN_W bits and never overflows.
- rst mid-burst: immediate return to IDLE, m_valid drops asynchronously. A pending native request is abandoned, and the memory side must tolerate it.

Test Plan:
- Single read: s_addr=0x100, s_len=0, memory returns 0xDEADBEEF after 3 wait cycles -> one m_valid request at 0x100; s_rdata=0xDEADBEEF, s_last=1 in RHOLD; done pulses once; busy falls.
- Read burst with backpressure: s_addr=0x200, s_len=3, unit drops s_valid for 5 cycles at beat 1 -> m_addr 0x200,0x204,0x208,0x20C in order; beat 1 held stable; s_last only on beat 3; 4 transfers total.
- Write burst: s_wstrb=0xF, s_len=1, s_wdata 0x11 then 0x22, m_ready immediate -> m_wdata 0x11@0x300, 0x22@0x304; m_wstrb=0xF on both; done after second.
- Address wrap: ADDR_W=32, s_addr=0xFFFFFFFC, s_len=1 -> m_addr 0xFFFFFFFC then 0x00000000.
- Reset mid-burst: s_len=7, assert rst during RREQ of beat 2 -> m_valid, s_ready, busy = 0 immediately. After release, a new burst s_addr=0x40, s_len=0 completes normally from cnt=0.
- Back-to-back: s_valid held 1 across two read bursts with s_len=0 -> second burst starts in the done cycle; its base is re-sampled from s_addr.
